sequence_stats_collector: RTL and testbench

- Downstream consumer of the sequence generator's output stream (sequence_value, done).
- Accumulates per-run statistics over the samples: count, sum, min and max. Checks each sample against the configured range and, optionally, against the expected step.
- On a rising edge of done it emits one summary record through a valid/ready handshake.

---
 rtl/sequence_stats_collector_if.sv | 32 +++
 rtl/sequence_stats_collector.sv | 200 ++++++++++++++++++++
 tb/tb_sequence_stats_collector.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sequence_stats_collector_if.sv
// Sample stream into the statistics collector and summary record out.
// The record side is a valid/ready handshake; master drives samples, slave reports.
interface sequence_stats_collector_if #(
    parameter int WIDTH   = 32,
    parameter int COUNT_W = 16,
    parameter int SUM_W   = 48
);
    logic                    in_valid;
    logic signed [WIDTH-1:0] in_value;
    logic                    in_done;
    logic                    out_valid;
    logic                    out_ready;
    logic [COUNT_W-1:0]      out_count;
    logic signed [SUM_W-1:0] out_sum;
    logic signed [WIDTH-1:0] out_min;
    logic signed [WIDTH-1:0] out_max;
    logic                    out_range_err;
    logic                    out_overrun;
    logic [COUNT_W-1:0]      out_step_err_cnt;

    modport master (
        output in_valid, in_value, in_done, out_ready,
        input  out_valid, out_count, out_sum, out_min, out_max,
        input  out_range_err, out_overrun, out_step_err_cnt
    );

    modport slave (
        input  in_valid, in_value, in_done, out_ready,
        output out_valid, out_count, out_sum, out_min, out_max,
        output out_range_err, out_overrun, out_step_err_cnt
    );
endinterface

// File: rtl/sequence_stats_collector.sv
// Per-run count/sum/min/max/range statistics, one record per done rising edge.
// Optional step checking is enabled with `define SEQ_STATS_STEP_CHECK_EN.
module sequence_stats_collector #(
    parameter int WIDTH   = 32,
    parameter int COUNT_W = 16,
    parameter int SUM_W   = 48
) (
    input  logic                    clk,
    input  logic                    rst,
    sequence_stats_collector_if.slave bus,
    input  logic signed [WIDTH-1:0] range_min,
    input  logic signed [WIDTH-1:0] range_max,
    input  logic signed [WIDTH-1:0] exp_step,
    output logic                    busy
);
    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        REPORT
    } state_t;

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;
    localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    state_t                  state;
    logic                    done_q;
    logic [COUNT_W-1:0]      cnt;
    logic signed [SUM_W-1:0] sum;
    logic signed [WIDTH-1:0] mn;
    logic signed [WIDTH-1:0] mx;
    logic                    rerr;
    logic                    ovr_pend;

    logic                    r_valid;
    logic [COUNT_W-1:0]      r_count;
    logic signed [SUM_W-1:0] r_sum;
    logic signed [WIDTH-1:0] r_min;
    logic signed [WIDTH-1:0] r_max;
    logic                    r_rerr;
    logic                    r_ovr;

    logic signed [WIDTH-1:0] v;
    logic signed [SUM_W-1:0] v_ext;
    logic                    trig;
    logic                    take;
    logic                    first;
    logic                    v_err;
    logic                    enter_rep;
    logic                    acc_clr;

    logic [COUNT_W-1:0]      nx_cnt;
    logic signed [SUM_W-1:0] nx_sum;
    logic signed [WIDTH-1:0] nx_min;
    logic signed [WIDTH-1:0] nx_max;
    logic                    nx_rerr;

    assign v         = bus.in_value;
    assign v_ext     = {{(SUM_W-WIDTH){v[WIDTH-1]}}, v};
    assign trig      = bus.in_done & ~done_q;
    assign take      = bus.in_valid && (state != REPORT);
    assign first     = (state == IDLE);
    assign v_err     = (v < range_min) || (v > range_max);
    assign enter_rep = trig && (state != REPORT);
    assign acc_clr   = (state == REPORT) && r_valid && bus.out_ready;
    assign busy      = (state != IDLE);

    // Accumulator values after folding in this cycle's sample (if any).
    always_comb begin
        nx_cnt  = cnt;
        nx_sum  = sum;
        nx_min  = mn;
        nx_max  = mx;
        nx_rerr = rerr;
        if (take) begin
            if (first) begin
                nx_cnt = CNT_ONE;
                nx_sum = v_ext;
                nx_min = v;
                nx_max = v;
            end else begin
                if (cnt != CNT_MAX) nx_cnt = cnt + CNT_ONE;
                nx_sum = sum + v_ext;
                if (v < mn) nx_min = v;
                if (v > mx) nx_max = v;
            end
            if (v_err) nx_rerr = 1'b1;
        end
    end

    // Run FSM: accumulate, latch the record on a done edge, clear on handoff.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            done_q   <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            mn       <= '0;
            mx       <= '0;
            rerr     <= 1'b0;
            ovr_pend <= 1'b0;
            r_valid  <= 1'b0;
            r_count  <= '0;
            r_sum    <= '0;
            r_min    <= '0;
            r_max    <= '0;
            r_rerr   <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            done_q <= bus.in_done;
            unique case (state)
                IDLE, ACCUM: begin
                    if (take) begin
                        cnt  <= nx_cnt;
                        sum  <= nx_sum;
                        mn   <= nx_min;
                        mx   <= nx_max;
                        rerr <= nx_rerr;
                    end
                    if (trig) begin
                        r_valid  <= 1'b1;
                        r_count  <= nx_cnt;
                        r_sum    <= nx_sum;
                        r_min    <= nx_min;
                        r_max    <= nx_max;
                        r_rerr   <= nx_rerr;
                        r_ovr    <= ovr_pend;
                        ovr_pend <= 1'b0;
                        state    <= REPORT;
                    end else if (take) begin
                        state <= ACCUM;
                    end
                end
                REPORT: begin
                    if (bus.in_valid) ovr_pend <= 1'b1;
                    if (acc_clr) begin
                        r_valid <= 1'b0;
                        cnt     <= '0;
                        sum     <= '0;
                        mn      <= '0;
                        mx      <= '0;
                        rerr    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SEQ_STATS_STEP_CHECK_EN
    logic signed [WIDTH-1:0] prev;
    logic [COUNT_W-1:0]      serr;
    logic [COUNT_W-1:0]      nx_serr;
    logic [COUNT_W-1:0]      r_serr;
    logic signed [WIDTH:0]   diff;
    logic                    step_bad;

    // Step mismatch detection; bound values are wrap/clamp points and exempt.
    always_comb begin
        diff     = {v[WIDTH-1], v} - {prev[WIDTH-1], prev};
        step_bad = take && !first
                && (v != range_min) && (v != range_max)
                && (diff != {exp_step[WIDTH-1], exp_step});
        nx_serr  = serr;
        if (step_bad && (serr != CNT_MAX)) nx_serr = serr + CNT_ONE;
    end

    // Step error counter, previous sample and its record copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev   <= '0;
            serr   <= '0;
            r_serr <= '0;
        end else begin
            if (acc_clr) begin
                prev <= '0;
                serr <= '0;
            end else if (take) begin
                prev <= v;
                serr <= nx_serr;
            end
            if (enter_rep) r_serr <= nx_serr;
        end
    end

    assign bus.out_step_err_cnt = r_serr;
`else
    logic unused_step;
    assign unused_step          = ^{exp_step, enter_rep};
    assign bus.out_step_err_cnt = '0;
`endif

    assign bus.out_valid     = r_valid;
    assign bus.out_count     = r_count;
    assign bus.out_sum       = r_sum;
    assign bus.out_min       = r_min;
    assign bus.out_max       = r_max;
    assign bus.out_range_err = r_rerr;
    assign bus.out_overrun   = r_ovr;
endmodule

// File: tb/tb_sequence_stats_collector.sv
// Bench for sequence_stats_collector: directed table, corner sequences and
// randomized traffic checked against a queue-based run model.
module tb_sequence_stats_collector;
    localparam int WIDTH   = 32;
    localparam int COUNT_W = 16;
    localparam int SUM_W   = 48;
    localparam longint MASK48 = 64'h0000_FFFF_FFFF_FFFF;

    logic                    clk = 1'b0;
    logic                    rst;
    logic signed [WIDTH-1:0] range_min;
    logic signed [WIDTH-1:0] range_max;
    logic signed [WIDTH-1:0] exp_step;
    logic                    busy;

    sequence_stats_collector_if #(
        .WIDTH(WIDTH), .COUNT_W(COUNT_W), .SUM_W(SUM_W)
    ) bus ();

    sequence_stats_collector #(
        .WIDTH(WIDTH), .COUNT_W(COUNT_W), .SUM_W(SUM_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .range_min(range_min),
        .range_max(range_max),
        .exp_step(exp_step),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    function automatic void chk(string name, logic signed [63:0] act,
                                logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int v;
        bit rerr;
        bit serr;
    } smp_t;

    smp_t   q[$];
    bit     m_pend, m_ovr, m_pdone;
    int     e_cnt, e_min, e_max, e_serr;
    longint e_sum;
    bit     e_rerr, e_ovr;

    function automatic void push_sample(int val);
        smp_t s;
        s.v    = val;
        s.rerr = (val < range_min) || (val > range_max);
        s.serr = 0;
`ifdef SEQ_STATS_STEP_CHECK_EN
        if (q.size() > 0 && val != range_min && val != range_max &&
            (longint'(val) - longint'(q[$].v)) != longint'(exp_step))
            s.serr = 1;
`endif
        q.push_back(s);
    endfunction

    function automatic void build_record();
        e_cnt  = (q.size() > 65535) ? 65535 : q.size();
        e_sum  = 0;
        e_min  = 0;
        e_max  = 0;
        e_rerr = 0;
        e_serr = 0;
        foreach (q[i]) begin
            e_sum += q[i].v;
            if (i == 0 || q[i].v < e_min) e_min = q[i].v;
            if (i == 0 || q[i].v > e_max) e_max = q[i].v;
            e_rerr |= q[i].rerr;
            if (q[i].serr && e_serr < 65535) e_serr++;
        end
        e_ovr = m_ovr;
        m_ovr = 0;
    endfunction

    function automatic void model_step();
        bit trig;
        if (rst) begin
            q.delete();
            m_pend  = 0;
            m_ovr   = 0;
            m_pdone = 0;
        end else begin
            trig    = bus.in_done && !m_pdone;
            m_pdone = bus.in_done;
            if (m_pend) begin
                if (bus.in_valid) m_ovr = 1;
                if (bus.out_ready) m_pend = 0;
            end else begin
                if (bus.in_valid) push_sample(int'(bus.in_value));
                if (trig) begin
                    build_record();
                    m_pend = 1;
                    q.delete();
                end
            end
        end
    endfunction

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Cycle monitor against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("m_valid", bus.out_valid, m_pend);
            chk("m_busy", busy, m_pend || q.size() != 0);
            if (m_pend) begin
                chk("m_count", bus.out_count, e_cnt);
                chk("m_sum", {16'd0, bus.out_sum}, e_sum & MASK48);
                chk("m_min", bus.out_min, e_min);
                chk("m_max", bus.out_max, e_max);
                chk("m_rerr", bus.out_range_err, e_rerr);
                chk("m_ovr", bus.out_overrun, e_ovr);
                chk("m_serr", bus.out_step_err_cnt, e_serr);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit v, int val, bit d, bit r);
        bus.in_valid  = v;
        bus.in_value  = val;
        bus.in_done   = d;
        bus.out_ready = r;
    endtask

    function automatic void chk_rec(string t, int c, longint s, int mn,
                                    int mx, bit re, bit ov);
        chk({t, "_valid"}, bus.out_valid, 1);
        chk({t, "_count"}, bus.out_count, c);
        chk({t, "_sum"}, {16'd0, bus.out_sum}, s & MASK48);
        chk({t, "_min"}, bus.out_min, mn);
        chk({t, "_max"}, bus.out_max, mx);
        chk({t, "_rerr"}, bus.out_range_err, re);
        chk({t, "_ovr"}, bus.out_overrun, ov);
    endfunction

    task automatic run(int n, int v0, int v1, int v2);
        int vals[3];
        vals = '{v0, v1, v2};
        for (int k = 0; k < n; k++) begin
            drive(1, vals[k], 0, 0);
            tick();
        end
        drive(0, 0, 1, 0);
        tick();
    endtask

    task automatic accept();
        drive(0, 0, 1, 1);
        tick();
        chk("acc_drop", bus.out_valid, 0);
        drive(0, 0, 0, 0);
        tick();
    endtask

    typedef struct {
        int     n;
        int     v[5];
        int     rmin;
        int     rmax;
        int     hold;
        int     e_cnt;
        longint e_sum;
        int     e_min;
        int     e_max;
        bit     e_rerr;
    } vec_t;

    vec_t tbl[5];
    bit   dn;

    initial begin
        tbl[0] = '{4, '{10, 12, 14, 16, 0}, 5, 20, 0, 4, 52, 10, 16, 1'b0};
        tbl[1] = '{3, '{4, 8, 21, 0, 0}, 5, 20, 5, 3, 33, 4, 21, 1'b1};
        tbl[2] = '{0, '{0, 0, 0, 0, 0}, 5, 20, 1, 0, 0, 0, 0, 1'b0};
        tbl[3] = '{2, '{3, -7, 0, 0, 0}, 10, 0, 0, 2, -4, -7, 3, 1'b1};
        tbl[4] = '{3, '{-100, 50, -3, 0, 0}, -200, 200, 2, 3, -53, -100, 50,
                   1'b0};

        rst       = 1;
        range_min = 5;
        range_max = 20;
        exp_step  = 2;
        drive(0, 0, 0, 0);
        tick();
        chk_en = 1;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", bus.out_count, 0);
        chk("rst_sum", {16'd0, bus.out_sum}, 0);
        tick();
        rst = 0;

        // Table-driven runs, with optional backpressure and held done.
        for (int i = 0; i < 5; i++) begin
            range_min = tbl[i].rmin;
            range_max = tbl[i].rmax;
            for (int k = 0; k < tbl[i].n; k++) begin
                drive(1, tbl[i].v[k], 0, 0);
                tick();
            end
            drive(0, 0, 1, 0);
            tick();
            chk_rec($sformatf("tbl%0d", i), tbl[i].e_cnt, tbl[i].e_sum,
                    tbl[i].e_min, tbl[i].e_max, tbl[i].e_rerr, 0);
            for (int h = 0; h < tbl[i].hold; h++) begin
                tick();
                chk_rec($sformatf("tbl%0d_hold", i), tbl[i].e_cnt,
                        tbl[i].e_sum, tbl[i].e_min, tbl[i].e_max,
                        tbl[i].e_rerr, 0);
            end
            drive(0, 0, 1, 1);
            tick();
            chk("tbl_accept", bus.out_valid, 0);
            for (int h = 0; h < 3; h++) begin
                tick();
                chk("tbl_noretrig", bus.out_valid, 0);
            end
            drive(0, 0, 0, 0);
            tick();
        end

        // Sample in the same cycle as the trigger.
        range_min = 5;
        range_max = 20;
        drive(1, 7, 1, 0);
        tick();
        chk_rec("simul", 1, 7, 7, 7, 0, 0);
        accept();

        // Overrun while a record is pending.
        range_min = 0;
        range_max = 100;
        run(2, 1, 2, 0);
        drive(1, 9, 1, 0);
        tick();
        drive(1, 11, 1, 0);
        tick();
        chk_rec("ovr_hold", 2, 3, 1, 2, 0, 0);
        accept();
        run(2, 5, 6, 0);
        chk_rec("ovr_next", 2, 11, 5, 6, 0, 1);
        accept();
        run(1, 1, 0, 0);
        chk_rec("ovr_clr", 1, 1, 1, 1, 0, 0);
        accept();

        // Reset in the middle of a run.
        drive(1, 10, 0, 0);
        tick();
        drive(1, 12, 0, 0);
        tick();
        rst = 1;
        drive(0, 0, 0, 0);
        tick();
        rst = 0;
        chk("rst_mid_valid", bus.out_valid, 0);
        chk("rst_mid_busy", busy, 0);
        run(1, 3, 0, 0);
        chk_rec("rst_after", 1, 3, 3, 3, 0, 0);
        accept();

        // Step check: only 12 -> 15 mismatches; 20 and 5 are bounds.
        range_min = 5;
        range_max = 20;
        exp_step  = 2;
        for (int k = 0; k < 5; k++) begin
            drive(1, (k == 0) ? 10 : (k == 1) ? 12 : (k == 2) ? 15 :
                     (k == 3) ? 20 : 5, 0, 0);
            tick();
        end
        drive(0, 0, 1, 0);
        tick();
        chk_rec("step", 5, 62, 5, 20, 0, 0);
`ifdef SEQ_STATS_STEP_CHECK_EN
        chk("step_cnt", bus.out_step_err_cnt, 1);
`else
        chk("step_cnt", bus.out_step_err_cnt, 0);
`endif
        accept();

        // Count saturation.
        range_min = 0;
        range_max = 10;
        exp_step  = 0;
        for (int k = 0; k < 65540; k++) begin
            drive(1, 1, 0, 0);
            tick();
        end
        drive(0, 0, 1, 0);
        tick();
        chk_rec("sat", 65535, 65540, 1, 1, 0, 0);
        accept();

        // Randomized traffic against the model.
        dn = 0;
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 49) == 0) begin
                range_min = int'($urandom_range(0, 20)) - 10;
                range_max = int'($urandom_range(0, 20)) - 5;
                exp_step  = int'($urandom_range(0, 3)) - 1;
            end
            if ($urandom_range(0, 7) == 0) dn = ~dn;
            drive($urandom_range(0, 2) != 0,
                  ($urandom_range(0, 30) == 0) ? int'($urandom())
                                               : int'($urandom_range(0, 40)) - 20,
                  dn, $urandom_range(0, 3) != 0);
            tick();
        end
        rst = 0;
        drive(0, 0, 0, 1);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
